// File: rtl/mm_pcpi_pkg.sv
// mm_pcpi_pkg: shared PCPI encodings, group address map, loader state enum and group helpers
package mm_pcpi_pkg;
    localparam logic [6:0] OPC_CUSTOM = 7'b0001011;
    localparam logic [2:0] F3_LOAD    = 3'b000;
    localparam logic [2:0] F3_STOP    = 3'b101;
    localparam logic [2:0] F3_RUN     = 3'b111;
    localparam logic [4:0] ADDR_A     = 5'd0;
    localparam logic [4:0] ADDR_B     = 5'd9;
    localparam logic [4:0] ADDR_BIAS  = 5'd18;
    localparam logic [4:0] ADDR_THR   = 5'd27;
    // the coprocessor expects address field 1 on the stop request
    localparam logic [4:0] STOP_ADDR  = 5'd1;
    typedef enum logic [3:0] {IDLE, LO, HI, ISSUE, GAP, RUN_ISSUE, RUN_WAIT, STOP_ISSUE, DONE} state_t;
    function automatic logic [4:0] grp_base(input logic [2:0] g);
        return g == 3'd0 ? ADDR_A : g == 3'd1 ? ADDR_B : g == 3'd2 ? ADDR_BIAS : ADDR_THR;
    endfunction
    function automatic logic [4:0] grp_last(input logic [2:0] g);
        return g >= 3'd3 ? ADDR_THR : grp_base(g) + 5'd8;
    endfunction
    // lowest selected group index >= from; 4 means no selected group remains
    function automatic logic [2:0] next_grp(input logic [3:0] sel, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int g = 3; g >= 0; g--)
            if (3'(g) >= from && sel[g]) r = 3'(g);
        return r;
    endfunction
endpackage

// File: rtl/mm_pcpi_req.sv
// mm_pcpi_req: PCPI valid/ready request handshake and inter-request gap timing
// Ports: clk, resetn (sync, active low); req holds pcpi_valid high with insn driven;
// gap marks idle cycles between requests; ack = request completed this cycle;
// gap_done = last idle cycle of the gap.
module mm_pcpi_req #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        gap,
    input  logic [31:0] insn,
    input  logic        pcpi_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic        ack,
    output logic        gap_done
);
    logic [1:0] gap_cnt;
    always_ff @(posedge clk) begin
        if (!resetn || !gap) gap_cnt <= '0;
        else gap_cnt <= gap_cnt + 2'd1;
    end
    assign pcpi_valid = req;
    assign pcpi_insn  = req ? insn : 32'd0;
    assign ack        = req && pcpi_ready;
    assign gap_done   = gap && gap_cnt == 2'(GAP_CYCLES - 1);
endmodule

// File: rtl/mm_pcpi_loader.sv
// mm_pcpi_loader: turns a host byte stream into PCPI load/run/stop requests for a matrix coprocessor
// Ports: clk, resetn (sync, active low); in_valid/in_data/in_ready host byte stream;
// pcpi_valid/pcpi_insn/pcpi_ready/pcpi_wait coprocessor request channel;
// busy (not idle), done (one-cycle pulse), err (sticky until next command byte).
// Build option: MM_LOADER_TIMEOUT_EN adds a 255-cycle request timeout that sets err.
module mm_pcpi_loader
    import mm_pcpi_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_ready,
    input  logic        pcpi_wait,
    output logic        busy,
    output logic        done,
    output logic        err
);
    state_t      state, state_n;
    logic [4:0]  cmd, addr;
    logic [2:0]  grp, ng, first_g;
    logic [7:0]  lo;
    logic [15:0] word;
    logic        stopping, rdy_ok, acc, req, ack, gap_done, tmo, grp_end;
    logic [31:0] insn;
    // rdy_ok keeps in_ready low in the cycle right after a reset edge
    assign in_ready = rdy_ok && (state == IDLE || state == LO || state == HI);
    assign acc      = in_valid && in_ready;
    assign req      = state inside {ISSUE, RUN_ISSUE, RUN_WAIT, STOP_ISSUE};
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign first_g  = next_grp(in_data[3:0], 3'd0);
    assign ng       = next_grp(cmd[3:0], grp + 3'd1);
    assign grp_end  = addr == grp_last(grp);
    assign insn     = state == ISSUE      ? {1'b0, word, F3_LOAD, addr, OPC_CUSTOM}
                    : state == STOP_ISSUE ? {17'd0, F3_STOP, STOP_ADDR, OPC_CUSTOM}
                    :                       {17'd0, F3_RUN, 5'd0, OPC_CUSTOM};
    mm_pcpi_req #(.GAP_CYCLES(GAP_CYCLES)) u_req (
        .clk(clk), .resetn(resetn), .req(req), .gap(state == GAP), .insn(insn),
        .pcpi_ready(pcpi_ready), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .ack(ack), .gap_done(gap_done)
    );
`ifdef MM_LOADER_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;
    always_ff @(posedge clk) begin
        if (!resetn || !req) tmo_cnt <= '0;
        else tmo_cnt <= tmo_cnt + 8'd1;
    end
    // 255th consecutive request cycle
    assign tmo = req && tmo_cnt == 8'd254;
    always_ff @(posedge clk) begin
        if (!resetn) err_q <= 1'b0;
        else if (tmo) err_q <= 1'b1;
        else if (state == IDLE && acc) err_q <= 1'b0;
    end
    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (acc) state_n = |in_data[3:0] ? LO : in_data[4] ? RUN_ISSUE : DONE;
            LO:         if (acc) state_n = HI;
            HI:         if (acc) state_n = ISSUE;
            ISSUE:      if (ack) state_n = GAP;
            GAP:        if (gap_done) state_n = stopping ? STOP_ISSUE
                                              : (!grp_end || !ng[2]) ? LO
                                              : cmd[4] ? RUN_ISSUE : DONE;
            RUN_ISSUE:  if (pcpi_wait) state_n = RUN_WAIT;
            RUN_WAIT:   if (pcpi_ready && !pcpi_wait) state_n = GAP;
            STOP_ISSUE: if (ack) state_n = DONE;
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        if (tmo) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_ok   <= 1'b0;
            cmd      <= '0;
            grp      <= '0;
            addr     <= '0;
            lo       <= '0;
            word     <= '0;
            stopping <= 1'b0;
        end else begin
            rdy_ok <= 1'b1;
            if (state == IDLE && acc) begin
                cmd      <= in_data[4:0];
                grp      <= first_g;
                addr     <= grp_base(first_g);
                stopping <= 1'b0;
            end
            if (state == LO && acc) lo <= in_data;
            if (state == HI && acc) word <= {in_data, lo};
            if (state == GAP && gap_done && !stopping) begin
                if (!grp_end) addr <= addr + 5'd1;
                else begin
                    grp  <= ng;
                    addr <= grp_base(ng);
                end
            end
            if (state == RUN_WAIT && pcpi_ready && !pcpi_wait) stopping <= 1'b1;
        end
    end
endmodule
